// File: rtl/bft_rx_stream_port.sv
// Receive endpoint for one leaf input port: filters BFT packets by port, buffers payloads,
// streams them to the kernel over ap_vld/ap_ack and returns freespace credit packets.
`timescale 1ns/1ps
module bft_rx_stream_port #(
  parameter int unsigned PACKET_BITS           = 49,
  parameter int unsigned PAYLOAD_BITS          = 32,
  parameter int unsigned NUM_LEAF_BITS         = 5,
  parameter int unsigned NUM_PORT_BITS         = 4,
  parameter int unsigned NUM_ADDR_BITS         = 7,
  parameter int unsigned FIFO_DEPTH_BITS       = 7,
  parameter int unsigned FREESPACE_UPDATE_SIZE = 64,
  parameter int unsigned PORT_ID               = 2,
  parameter int unsigned SRC_LEAF              = 0,
  parameter int unsigned SRC_PORT              = 1
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [PACKET_BITS-1:0]     din_pkt,
  output logic [PACKET_BITS-1:0]     dout_credit_pkt,
  output logic [PAYLOAD_BITS-1:0]    Input_V_V,
  output logic                       Input_V_V_ap_vld,
  input  logic                       Input_V_V_ap_ack,
  output logic                       overflow,
  output logic [FIFO_DEPTH_BITS:0]   fill_level
);

  localparam int unsigned Depth = 1 << FIFO_DEPTH_BITS;
  localparam int unsigned CredW = $clog2(FREESPACE_UPDATE_SIZE) + 1;
  localparam int unsigned FillW = FIFO_DEPTH_BITS + 1;
  localparam logic [FillW-1:0] FullLevel = FillW'(Depth);
  localparam logic [CredW-1:0] CredStep = CredW'(FREESPACE_UPDATE_SIZE);
  localparam logic [NUM_PORT_BITS-1:0] PortId = NUM_PORT_BITS'(PORT_ID);
  localparam logic [PACKET_BITS-1:0] CreditPkt = {1'b1, NUM_LEAF_BITS'(SRC_LEAF),
      NUM_PORT_BITS'(SRC_PORT), NUM_ADDR_BITS'(PORT_ID), PAYLOAD_BITS'(FREESPACE_UPDATE_SIZE)};

  logic [PAYLOAD_BITS-1:0]    mem [Depth];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FillW-1:0]           fill_q, fill_d, ram_cnt;
  logic [PAYLOAD_BITS-1:0]    data_q, data_d;
  logic                       vld_q, vld_d, ovf_q, ovf_d;
  logic [CredW-1:0]           cred_cnt_q, cred_cnt_d;
  logic [PACKET_BITS-1:0]     credit_q, credit_d;
  logic                       push_req, push, pop, load, full;
  logic [NUM_PORT_BITS-1:0]   din_port;
  logic                       unused_pkt_fields;

  assign din_port = din_pkt[PAYLOAD_BITS+NUM_ADDR_BITS +: NUM_PORT_BITS];
  assign unused_pkt_fields = ^{din_pkt[PAYLOAD_BITS +: NUM_ADDR_BITS],
                               din_pkt[PACKET_BITS-2 -: NUM_LEAF_BITS]};

  always_comb begin
    push_req = din_pkt[PACKET_BITS-1] && (din_port == PortId);
    pop      = vld_q && Input_V_V_ap_ack;
    // Words still in RAM exclude the one sitting in the output register.
    ram_cnt  = fill_q - FillW'(vld_q);
    full     = (fill_q == FullLevel);
    push     = push_req && (!full || pop);
    load     = (ram_cnt != '0) && (!vld_q || pop);

    wr_ptr_d = push ? wr_ptr_q + FIFO_DEPTH_BITS'(1) : wr_ptr_q;
    rd_ptr_d = load ? rd_ptr_q + FIFO_DEPTH_BITS'(1) : rd_ptr_q;
    vld_d    = load || (vld_q && !pop);
    data_d   = load ? mem[rd_ptr_q] : data_q;
    fill_d   = fill_q + FillW'(push) - FillW'(pop);
    ovf_d    = ovf_q || (push_req && !push);

    if (cred_cnt_q >= CredStep) begin
      cred_cnt_d = cred_cnt_q - CredStep + CredW'(pop);
    end else begin
      cred_cnt_d = cred_cnt_q + CredW'(pop);
    end
    // The credit is visible in exactly the cycle in which the counter holds a full batch.
    credit_d = (cred_cnt_d >= CredStep) ? CreditPkt : '0;
  end

  always_ff @(posedge ap_clk) begin
    if (push) begin
      mem[wr_ptr_q] <= din_pkt[PAYLOAD_BITS-1:0];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      data_q     <= '0;
      vld_q      <= 1'b0;
      ovf_q      <= 1'b0;
      cred_cnt_q <= '0;
      credit_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      data_q     <= data_d;
      vld_q      <= vld_d;
      ovf_q      <= ovf_d;
      cred_cnt_q <= cred_cnt_d;
      credit_q   <= credit_d;
    end
  end

  assign dout_credit_pkt  = credit_q;
  assign Input_V_V        = data_q;
  assign Input_V_V_ap_vld = vld_q;
  assign overflow         = ovf_q;
  assign fill_level       = fill_q;

endmodule

// File: doc/bft_rx_stream_port.md
# bft_rx_stream_port

Single-clock receive endpoint for one leaf input port. It accepts 49-bit BFT packets addressed to its port and buffers their payloads in a FIFO. It presents the payloads to a user kernel on an `ap_vld`/`ap_ack` stream, and returns freespace credit packets to the sending leaf. It is the receiver counterpart of the kernel-side `Output_*_ap_vld`/`ap_ack` producer and sits between the leaf packet bus and the kernel's `Input_*_V_V` port.

## Interface
- PACKET_BITS, 49, packet width
- PAYLOAD_BITS, 32, payload width
- NUM_LEAF_BITS, 5, leaf address field width
- NUM_PORT_BITS, 4, port field width
- NUM_ADDR_BITS, 7, addr field width
- FIFO_DEPTH_BITS, 7, total buffer capacity is 2^FIFO_DEPTH_BITS words, including the output stage
- FREESPACE_UPDATE_SIZE, 64, number of pops per credit packet
- PORT_ID, 2, port number this block accepts
- SRC_LEAF, 0, leaf that receives credit packets
- SRC_PORT, 1, port that receives credit packets
- ap_clk  in  1  sole clock; everything is rising-edge
- ap_rst_n  in  1  asynchronous, active-low reset
- din_pkt  in  PACKET_BITS  incoming packet
- dout_credit_pkt  out  PACKET_BITS  credit packet toward the BFT
- Input_V_V  out  PAYLOAD_BITS  stream data (head word)
- Input_V_V_ap_vld  out  1  head word valid
- Input_V_V_ap_ack  in  1  kernel accepts the head word
- overflow  out  1  sticky; set when a packet is dropped
- fill_level  out  FIFO_DEPTH_BITS+1  words currently held

## Operation
- Packet layout:
  - [48] valid
  - [47:43] leaf
  - [42:39] port
  - [38:32] addr
  - [31:0] payload
- Accept condition: din_pkt[48]=1 and port==PORT_ID. All other packets, including valid=0, are ignored with no side effect.
- Accepted packets push their payload. The leaf and addr fields are not checked.
- Storage: circular RAM with read and write pointers, plus one output register driving Input_V_V and ap_vld.
- fill_level counts words in RAM plus the output register. The buffer is full when fill_level==2^FIFO_DEPTH_BITS.
- Pop: a transfer occurs in any cycle with ap_vld=1 and ap_ack=1. ap_ack while ap_vld=0 is ignored.
- Output register behaviour:
  - Loads from RAM at an edge where it is empty or being popped, and RAM is non-empty.
  - Otherwise it clears vld on pop.
  - Data is held stable while vld=1 and ack=0.
- Overflow: a push while full (after accounting for a same-cycle pop) drops the word and sets overflow. Overflow stays set until reset.
- Push and pop in the same cycle: fill_level is unchanged. With fill_level==full and a simultaneous pop, the push is accepted.
- Credit counter cred_cnt (width log2(FREESPACE_UPDATE_SIZE)+1):
  - Increments by 1 per pop.
  - At the edge where cred_cnt>=FREESPACE_UPDATE_SIZE, it emits a credit packet and subtracts FREESPACE_UPDATE_SIZE (plus 1 if a pop also occurs).
- Credit packet fields: valid=1, leaf=SRC_LEAF, port=SRC_PORT, addr=PORT_ID, payload=FREESPACE_UPDATE_SIZE zero-extended.
- dout_credit_pkt is all zeros in every cycle that carries no credit.
- Pointers wrap modulo 2^FIFO_DEPTH_BITS.

## Timing
- Reset values, all asynchronous to ap_rst_n low:
  - Input_V_V=0, ap_vld=0
  - dout_credit_pkt=0
  - overflow=0, fill_level=0
  - pointers=0, cred_cnt=0
- Reset mid-operation discards all buffered words and any pending credit. No credit packet is emitted for partial counts.
- Latency: a packet present in cycle 0 is written at edge 0, and ap_vld=1 in cycle 2 when the buffer was empty.
- fill_level updates at the push edge, so it is 1 in cycle 1.
- Throughput: one accepted packet per cycle. With ap_ack held at 1, ap_vld stays continuously high after the initial fill.
- Credit timing: the pop that brings cred_cnt to FREESPACE_UPDATE_SIZE occurs at edge k. cred_cnt reads the new value after edge k, and the credit packet is valid for exactly cycle k+1, then returns to 0.
- Back-to-back credits can occur no closer than FREESPACE_UPDATE_SIZE cycles apart.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold ap_rst_n=0 with random din_pkt and ack → all outputs 0. Release ap_rst_n, then send one packet with valid=1, port=2, payload=0xDEADBEEF in cycle 0 → fill_level=1 in cycle 1; ap_vld=1 and Input_V_V=0xDEADBEEF in cycle 2; data held until ack.
- Filtering: send packets with port=3 and with valid=0, payload=0x12345678 → ap_vld stays 0 and fill_level stays 0.
- Backpressure and full: hold ack=0 and send 129 accepted packets with payloads 0..128 → fill_level=128 and overflow=1. Then hold ack=1 → the words pop in order 0..127 with vld continuous, and word 128 never appears.
- Credit: stream 130 words with ack=1 → exactly two credit packets, each valid one cycle after the 64th and 128th pops, with fields leaf=0, port=1, addr=2, payload=64. cred_cnt ends at 2.
- Simultaneous push and pop at full: at fill_level=128 with ack=1, push payload 0xA5 → fill_level remains 128, overflow stays 0, and 0xA5 is later delivered.
- Mid-stream reset: pulse ap_rst_n low with 40 words buffered and 63 pops counted → fill_level=0 and vld=0. The next 63 pops produce no credit, and the 64th pop does.
